knapsack_search_ctrl: RTL and testbench



---
 rtl/knapsack_search_ctrl.sv | 153 +++++++++++++++
 tb/tb_knapsack_search_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knapsack_search_ctrl.sv
// Exhaustive 0-1 knapsack search: walks every selection mask, one per cycle,
// and keeps the highest-value selection whose total weight fits the capacity.
module knapsack_search_ctrl #(
    parameter int N_ITEMS = 5,
    parameter int VW = 8,
    parameter int WW = 8,
    localparam int SW = ((VW > WW) ? VW : WW) + $clog2(N_ITEMS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_ITEMS*VW-1:0] item_value,
    input  logic [N_ITEMS*WW-1:0] item_weight,
    input  logic [SW-1:0]         capacity,
    input  logic [SW-1:0]         min_value,
    output logic                  busy,
    output logic                  done,
    output logic [N_ITEMS-1:0]    best_mask,
    output logic [SW-1:0]         best_value,
    output logic [SW-1:0]         best_weight,
    output logic                  found,
    output logic [N_ITEMS:0]      feasible_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // One spare bit on the counter so the all-ones compare never meets a wrap.
    localparam logic [N_ITEMS:0] LAST_MASK = {1'b0, {N_ITEMS{1'b1}}};

    state_t state, state_next;

    logic [N_ITEMS:0]      mask;
    logic [N_ITEMS*VW-1:0] value_q;
    logic [N_ITEMS*WW-1:0] weight_q;
    logic [SW-1:0]         capacity_q;
    logic [SW-1:0]         min_value_q;
    logic                  found_q;

    logic [SW-1:0] sum_v;
    logic [SW-1:0] sum_w;
    logic          feasible;
    logic          improve;
    logic          last_mask;

    always_comb begin
        sum_v = '0;
        sum_w = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (mask[i]) begin
                sum_v = sum_v + SW'(value_q[i*VW +: VW]);
                sum_w = sum_w + SW'(weight_q[i*WW +: WW]);
            end
        end
    end

    // Strict improvement only, so ties keep the earlier (lower) mask.
    assign feasible  = (sum_w <= capacity_q);
    assign improve   = feasible && (sum_v > best_value);
    assign last_mask = (mask == LAST_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last_mask) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask           <= '0;
            value_q        <= '0;
            weight_q       <= '0;
            capacity_q     <= '0;
            min_value_q    <= '0;
            best_mask      <= '0;
            best_value     <= '0;
            best_weight    <= '0;
            feasible_count <= '0;
            found_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        value_q        <= item_value;
                        weight_q       <= item_weight;
                        capacity_q     <= capacity;
                        min_value_q    <= min_value;
                        mask           <= '0;
                        best_mask      <= '0;
                        best_value     <= '0;
                        best_weight    <= '0;
                        feasible_count <= '0;
                        found_q        <= 1'b0;
                    end
                end
                SCAN: begin
                    if (feasible) begin
                        feasible_count <= feasible_count + (N_ITEMS+1)'(1);
                    end
                    if (improve) begin
                        best_mask   <= mask[N_ITEMS-1:0];
                        best_value  <= sum_v;
                        best_weight <= sum_w;
                    end
                    if (!last_mask) begin
                        mask <= mask + (N_ITEMS+1)'(1);
                    end
                end
                DONE: begin
                    found_q <= (best_value >= min_value_q);
                end
                default: begin
                end
            endcase
        end
    end

    // The final best is only settled in DONE, so found is derived there and held afterwards.
    assign found = (state == DONE) ? (best_value >= min_value_q) : found_q;

endmodule

// File: tb/tb_knapsack_search_ctrl.sv
// Self-checking bench for knapsack_search_ctrl: directed and random searches
// compared against a brute-force reference model.
module tb_knapsack_search_ctrl;

    localparam int N  = 5;
    localparam int VW = 8;
    localparam int WW = 8;
    localparam int SW = 12;
    localparam int NM = 32;
    localparam int LIMIT = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*VW-1:0] item_value;
    logic [N*WW-1:0] item_weight;
    logic [SW-1:0]   capacity;
    logic [SW-1:0]   min_value;
    logic            busy;
    logic            done;
    logic [N-1:0]    best_mask;
    logic [SW-1:0]   best_value;
    logic [SW-1:0]   best_weight;
    logic            found;
    logic [N:0]      feasible_count;

    int checks = 0;
    int failures = 0;

    knapsack_search_ctrl #(.N_ITEMS(N), .VW(VW), .WW(WW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .item_value     (item_value),
        .item_weight    (item_weight),
        .capacity       (capacity),
        .min_value      (min_value),
        .busy           (busy),
        .done           (done),
        .best_mask      (best_mask),
        .best_value     (best_value),
        .best_weight    (best_weight),
        .found          (found),
        .feasible_count (feasible_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Brute force over every subset, lowest mask first, strict improvement.
    task automatic model_search(input logic [N*VW-1:0] v, input logic [N*WW-1:0] w,
                                input int cap, input int minv,
                                output int bm, output int bv, output int bw,
                                output int fc, output bit fnd);
        int sv;
        int sw;
        bm = 0; bv = 0; bw = 0; fc = 0;
        for (int m = 0; m < NM; m++) begin
            sv = 0;
            sw = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    sv += int'(v[i*VW +: VW]);
                    sw += int'(w[i*WW +: WW]);
                end
            end
            if (sw <= cap) begin
                fc++;
                if (sv > bv) begin
                    bm = m; bv = sv; bw = sw;
                end
            end
        end
        fnd = (bv >= minv);
    endtask

    task automatic set_inputs(input logic [N*VW-1:0] v, input logic [N*WW-1:0] w,
                              input int cap, input int minv);
        item_value  = v;
        item_weight = w;
        capacity    = SW'(cap);
        min_value   = SW'(minv);
    endtask

    // Leaves the bench at the first negedge after the edge that samples start.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts negedges since the start-sampling edge; caller is already at n=1.
    task automatic wait_done(output int n, output bit timed_out);
        n = 1;
        while (done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic rand_vec(output logic [N*VW-1:0] v, output logic [N*WW-1:0] w);
        for (int i = 0; i < N; i++) begin
            v[i*VW +: VW] = VW'($urandom_range(0, 255));
            w[i*WW +: WW] = ($urandom_range(0, 4) == 0) ? '0 : WW'($urandom_range(0, 255));
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        set_inputs('1, '1, 100, 5);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b expected 0/0", busy, done);
        end
        checks++;
        if ({found, best_mask, best_value, best_weight, feasible_count} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_results: found=%b mask=%b value=%0d weight=%0d count=%0d expected all 0",
                     found, best_mask, best_value, best_weight, feasible_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [N*VW-1:0] dv[4];
        logic [N*WW-1:0] dw[4];
        int dcap[4];
        int dmin[4];
        int n, bm, bv, bw, fc;
        bit to, fnd;
        dv[0] = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4};  dw[0] = {8'd4, 8'd1, 8'd2, 8'd1, 8'd12};
        dcap[0] = 15; dmin[0] = 15;
        dv[1] = dv[0]; dw[1] = dw[0]; dcap[1] = 16; dmin[1] = 16;
        dv[2] = dv[0]; dw[2] = dw[0]; dcap[2] = 0;  dmin[2] = 1;
        dv[3] = {8'd0, 8'd0, 8'd0, 8'd3, 8'd3};   dw[3] = {8'd1, 8'd1, 8'd1, 8'd5, 8'd5};
        dcap[3] = 5; dmin[3] = 3;
        for (int k = 0; k < 4; k++) begin
            set_inputs(dv[k], dw[k], dcap[k], dmin[k]);
            model_search(dv[k], dw[k], dcap[k], dmin[k], bm, bv, bw, fc, fnd);
            launch();
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dir%0d_busy_start: got %b expected 1", k, busy);
            end
            wait_done(n, to);
            checks++;
            if (to || n != NM + 1) begin
                failures++;
                $display("[TB] FAIL dir%0d_latency: got %0d cycles (timeout=%0b) expected %0d", k, n, to, NM + 1);
            end
            checks++;
            if (best_mask !== N'(bm) || best_value !== SW'(bv) || best_weight !== SW'(bw)) begin
                failures++;
                $display("[TB] FAIL dir%0d_best: got mask=%b v=%0d w=%0d expected mask=%b v=%0d w=%0d",
                         k, best_mask, best_value, best_weight, N'(bm), bv, bw);
            end
            checks++;
            if (feasible_count !== (N+1)'(fc) || found !== fnd || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dir%0d_count_found: got count=%0d found=%b busy=%b expected %0d/%b/1",
                         k, feasible_count, found, busy, fc, fnd);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || found !== fnd || best_value !== SW'(bv)) begin
                failures++;
                $display("[TB] FAIL dir%0d_hold: got done=%b busy=%b found=%b v=%0d expected 0/0/%b/%0d",
                         k, done, busy, found, best_value, fnd, bv);
            end
        end
    endtask

    task automatic test_random();
        logic [N*VW-1:0] v;
        logic [N*WW-1:0] w;
        int cap, minv, n, bm, bv, bw, fc;
        bit to, fnd;
        for (int k = 0; k < 8; k++) begin
            rand_vec(v, w);
            cap  = $urandom_range(0, 700);
            minv = $urandom_range(0, 900);
            set_inputs(v, w, cap, minv);
            model_search(v, w, cap, minv, bm, bv, bw, fc, fnd);
            launch();
            wait_done(n, to);
            checks++;
            if (to || n != NM + 1) begin
                failures++;
                $display("[TB] FAIL rnd%0d_latency: got %0d cycles (timeout=%0b) expected %0d", k, n, to, NM + 1);
            end
            checks++;
            if (best_mask !== N'(bm) || best_value !== SW'(bv) || best_weight !== SW'(bw)) begin
                failures++;
                $display("[TB] FAIL rnd%0d_best: got mask=%b v=%0d w=%0d expected mask=%b v=%0d w=%0d",
                         k, best_mask, best_value, best_weight, N'(bm), bv, bw);
            end
            checks++;
            if (feasible_count !== (N+1)'(fc) || found !== fnd) begin
                failures++;
                $display("[TB] FAIL rnd%0d_count_found: got count=%0d found=%b expected %0d/%b",
                         k, feasible_count, found, fc, fnd);
            end
        end
    endtask

    task automatic test_mid_scan();
        logic [N*VW-1:0] va, vb;
        logic [N*WW-1:0] wa, wb;
        int cap, minv, n, bm, bv, bw, fc, pulses;
        bit to, fnd;
        rand_vec(va, wa);
        cap  = $urandom_range(100, 600);
        minv = $urandom_range(0, 600);
        set_inputs(va, wa, cap, minv);
        model_search(va, wa, cap, minv, bm, bv, bw, fc, fnd);
        launch();
        repeat (5) @(negedge clk);
        rand_vec(vb, wb);
        set_inputs(vb, wb, 0, 1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, to);
        n += 6;
        checks++;
        if (to || n != NM + 1) begin
            failures++;
            $display("[TB] FAIL mid_latency: got %0d cycles (timeout=%0b) expected %0d", n, to, NM + 1);
        end
        checks++;
        if (best_mask !== N'(bm) || best_value !== SW'(bv) || best_weight !== SW'(bw)
            || feasible_count !== (N+1)'(fc) || found !== fnd) begin
            failures++;
            $display("[TB] FAIL mid_result: got mask=%b v=%0d w=%0d c=%0d f=%b expected mask=%b v=%0d w=%0d c=%0d f=%b",
                     best_mask, best_value, best_weight, feasible_count, found, N'(bm), bv, bw, fc, fnd);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_extra_done: got %0d extra pulses busy=%b expected 0/0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [N*VW-1:0] v;
        logic [N*WW-1:0] w;
        int n, bm, bv, bw, fc, pulses;
        bit to, fnd;
        v = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4};
        w = {8'd4, 8'd1, 8'd2, 8'd1, 8'd12};
        set_inputs(v, w, 15, 15);
        model_search(v, w, 15, 15, bm, bv, bw, fc, fnd);
        launch();
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_before: busy=%b done=%b expected 1/0", busy, done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, found, best_mask, best_value, best_weight, feasible_count} !== '0) begin
            failures++;
            $display("[TB] FAIL rstmid_clear: busy=%b done=%b found=%b mask=%b v=%0d w=%0d c=%0d expected all 0",
                     busy, done, found, best_mask, best_value, best_weight, feasible_count);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL rstmid_no_done: got %0d busy/done cycles expected 0", pulses);
        end
        launch();
        wait_done(n, to);
        checks++;
        if (to || n != NM + 1 || best_mask !== N'(bm) || best_value !== SW'(bv)
            || feasible_count !== (N+1)'(fc) || found !== fnd) begin
            failures++;
            $display("[TB] FAIL rstmid_rerun: got n=%0d mask=%b v=%0d c=%0d f=%b expected n=%0d mask=%b v=%0d c=%0d f=%b",
                     n, best_mask, best_value, feasible_count, found, NM + 1, N'(bm), bv, fc, fnd);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*VW-1:0] va, vb;
        logic [N*WW-1:0] wa, wb;
        int capa, capb, n, bm, bv, bw, fc;
        bit to, fnd;
        rand_vec(va, wa);
        rand_vec(vb, wb);
        capa = $urandom_range(50, 500);
        capb = $urandom_range(50, 500);
        set_inputs(va, wa, capa, 200);
        model_search(va, wa, capa, 200, bm, bv, bw, fc, fnd);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        set_inputs(vb, wb, capb, 300);
        wait_done(n, to);
        checks++;
        if (to || n != NM + 1 || best_mask !== N'(bm) || best_value !== SW'(bv)
            || feasible_count !== (N+1)'(fc) || found !== fnd) begin
            failures++;
            $display("[TB] FAIL b2b_first: got n=%0d mask=%b v=%0d c=%0d f=%b expected n=%0d mask=%b v=%0d c=%0d f=%b",
                     n, best_mask, best_value, feasible_count, found, NM + 1, N'(bm), bv, fc, fnd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle_gap: busy=%b done=%b expected 0/0", busy, done);
        end
        model_search(vb, wb, capb, 300, bm, bv, bw, fc, fnd);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_relaunch: busy=%b expected 1", busy);
        end
        wait_done(n, to);
        checks++;
        if (to || n != NM + 1 || best_mask !== N'(bm) || best_value !== SW'(bv) || best_weight !== SW'(bw)
            || feasible_count !== (N+1)'(fc) || found !== fnd) begin
            failures++;
            $display("[TB] FAIL b2b_second: got n=%0d mask=%b v=%0d w=%0d c=%0d f=%b expected n=%0d mask=%b v=%0d w=%0d c=%0d f=%b",
                     n, best_mask, best_value, best_weight, feasible_count, found, NM + 1, N'(bm), bv, bw, fc, fnd);
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_mid_scan();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
